// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with
// memory wait-state timeout, halt/resume, sticky error flags and a retired-instruction count.
module mips_multicycle_ctrl #(
    parameter int ALUOP_W = 6,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               mem_ready,
    input  logic               resume,
    output logic               PCWriteCond,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic               isSigned,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               JumpAndLink,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err,
    output logic [CNT_W-1:0]   instret,
    output logic [3:0]         state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_R_WB     = 4'd4,
        S_JR       = 4'd5,
        S_I_EXEC   = 4'd6,
        S_I_WB     = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    localparam int         OPX    = (ALUOP_W > 6) ? ALUOP_W : 6;
    localparam int         WC_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0] OP_ADD = 6'b001001;

    state_t             state, next_state;
    logic [WC_W-1:0]    wait_cnt;
    logic [5:0]         opcode, funct;
    logic [OPX-1:0]     op_ext, add_ext;
    logic [ALUOP_W-1:0] op_alu, add_alu;
    logic               in_wait, timeout, retire, set_illegal;
    logic               unused_bits;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unused_bits = ^instr[25:6];

    // Opcode and ADD are zero-extended or truncated to the configured ALUOp width.
    assign op_ext  = OPX'(opcode);
    assign add_ext = OPX'(OP_ADD);
    assign op_alu  = op_ext[ALUOP_W-1:0];
    assign add_alu = add_ext[ALUOP_W-1:0];

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // mem_ready in the final allowed cycle wins over the timeout.
    assign timeout = (TIMEOUT != 0) && in_wait && !mem_ready &&
                     (wait_cnt == WC_W'(TIMEOUT - 1));

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            instret  <= '0;
        end else begin
            state <= next_state;
            if ((TIMEOUT != 0) && in_wait && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + WC_W'(1);
            else
                wait_cnt <= '0;
            if (set_illegal) illegal <= 1'b1;
            if (timeout)     bus_err <= 1'b1;
            if (retire)      instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        next_state  = state;
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        isSigned    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        JumpAndLink = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = '0;
        halted      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = add_alu;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = add_alu;
                case (opcode)
                    6'b000000:                        next_state = S_R_EXEC;
                    6'b000010, 6'b000011:             next_state = S_JUMP;
                    6'b000100, 6'b000101:             next_state = S_BRANCH;
                    6'b001001, 6'b001010, 6'b001100,
                    6'b001101, 6'b001110, 6'b010000:  next_state = S_I_EXEC;
                    6'b100011, 6'b101011:             next_state = S_MEM_ADDR;
                    6'b111111: begin
                        next_state = S_HALT;
                        retire     = 1'b1;
                    end
                    default: begin
                        next_state  = S_HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = op_alu;
                next_state = (funct == 6'b001000) ? S_JR : S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JR: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_I_EXEC, S_I_WB: begin
                // Writeback keeps the ALU inputs steady so the result stays valid.
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = op_alu;
                isSigned = (opcode == 6'b001001) || (opcode == 6'b001010);
                if (state == S_I_EXEC) begin
                    next_state = S_I_WB;
                end else begin
                    RegWrite   = 1'b1;
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUOp      = add_alu;
                isSigned   = 1'b1;
                next_state = (opcode == 6'b100011) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready)    next_state = S_MEM_WB;
                else if (timeout) next_state = S_HALT;
            end
            S_MEM_WB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_HALT;
                end
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = op_alu;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite     = 1'b1;
                PCSource    = 2'b10;
                JumpAndLink = (opcode == 6'b000011);
                RegWrite    = (opcode == 6'b000011);
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                // Errors are fatal until reset; only a clean halt may resume.
                if (resume && !illegal && !bus_err) next_state = S_FETCH;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs; a monitor compares every cycle.
module tb_mips_multicycle_ctrl;

    localparam int         TO  = 4;
    localparam int         CW  = 6;
    localparam logic [5:0] ADD = 6'b001001;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_R_EXEC = 4'd3,
                           S_R_WB = 4'd4, S_JR = 4'd5, S_I_EXEC = 4'd6, S_I_WB = 4'd7,
                           S_MEM_ADDR = 4'd8, S_MEM_RD = 4'd9, S_MEM_WB = 4'd10,
                           S_MEM_WR = 4'd11, S_BRANCH = 4'd12, S_JUMP = 4'd13, S_HALT = 4'd14;

    typedef struct packed {
        logic [3:0]    st;
        logic          pcwc, pcw, iord, mrd, mwr, m2r, irw, sgn, srca, rw, rdst, jal;
        logic [1:0]    pcsrc, srcb;
        logic [5:0]    aluop;
        logic          hlt, ill, berr;
        logic [CW-1:0] ret;
    } obs_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] instr = '0;
    logic mem_ready = 1'b0, resume = 1'b0;
    logic PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemToReg, IRWrite, isSigned;
    logic ALUSrcA, RegWrite, RegDst, JumpAndLink, halted, illegal, bus_err;
    logic [1:0] PCSource, ALUSrcB;
    logic [5:0] ALUOp;
    logic [CW-1:0] instret;
    logic [3:0] state_dbg;

    mips_multicycle_ctrl #(.ALUOP_W(6), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .resume(resume),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .IRWrite(IRWrite), .isSigned(isSigned),
        .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .JumpAndLink(JumpAndLink),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .halted(halted),
        .illegal(illegal), .bus_err(bus_err), .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int checks = 0, passes = 0, fails = 0;
    logic ill_m = 1'b0, berr_m = 1'b0;
    logic [CW-1:0] ret_m = '0;
    bit dead = 0;

    function automatic obs_t base(input logic [3:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        e.hlt = (st == S_HALT);
        e.ill = ill_m;
        e.berr = berr_m;
        e.ret = ret_m;
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a.st = state_dbg; a.pcwc = PCWriteCond; a.pcw = PCWrite; a.iord = IorD;
        a.mrd = MemRead; a.mwr = MemWrite; a.m2r = MemToReg; a.irw = IRWrite;
        a.sgn = isSigned; a.srca = ALUSrcA; a.rw = RegWrite; a.rdst = RegDst;
        a.jal = JumpAndLink; a.pcsrc = PCSource; a.srcb = ALUSrcB; a.aluop = ALUOp;
        a.hlt = halted; a.ill = illegal; a.berr = bus_err; a.ret = instret;
        return a;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E,
            6'h10, 6'h23, 6'h2B, 6'h3F: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] rand_op(input bit no_err);
        logic [5:0] ops [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0A,
                                 6'h0C, 6'h0D, 6'h0E, 6'h10, 6'h23, 6'h2B, 6'h3F};
        logic [5:0] o;
        int k = $urandom_range(0, no_err ? 13 : 14);
        if (k < 14) return ops[k];
        do o = 6'($urandom_range(0, 63)); while (is_legal(o));
        return o;
    endfunction

    function automatic int pick_wait(input bit no_err);
        if (!no_err && $urandom_range(0, 24) == 0) return $urandom_range(TO, TO + 2);
        return $urandom_range(0, TO - 1);
    endfunction

    // One clock cycle of stimulus plus the output expected during it.
    task automatic cyc(input logic [31:0] ins, input logic mr, input logic rs, input obs_t e);
        @(negedge clk);
        instr = ins;
        mem_ready = mr;
        resume = rs;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_ready = rb();
        resume = rb();
        ill_m = 1'b0; berr_m = 1'b0; ret_m = '0; dead = 0;
        exp_q.push_back(base(S_IDLE));
        @(negedge clk);
        exp_q.push_back(base(S_IDLE));
        @(negedge clk);
        rst = 1'b1;
        exp_q.push_back(base(S_IDLE));
    endtask

    // n cycles of memory not ready; gives up with a bus error after TO of them.
    task automatic wait_phase(input logic [31:0] ins, input obs_t e, input int n, output bit to);
        to = 0;
        for (int k = 0; k < n; k++) begin
            cyc(ins, 1'b0, rb(), e);
            if (k == TO - 1) begin
                berr_m = 1'b1;
                to = 1;
                break;
            end
        end
    endtask

    task automatic err_halt(input logic [31:0] ins, input int n);
        for (int i = 0; i < n; i++) cyc(ins, rb(), 1'b1, base(S_HALT));
        dead = 1;
    endtask

    // rst_mid: 1 = reset after the fetch waits, 2 = reset after the memory waits.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input int hc, input int rst_mid);
        obs_t e;
        bit to;
        logic [5:0] op;
        op = ins[31:26];
        e = base(S_FETCH); e.mrd = 1; e.srcb = 2'b01; e.aluop = ADD;
        wait_phase(ins, e, fw, to);
        if (to) begin err_halt(ins, hc); return; end
        if (rst_mid == 1) begin do_reset(); return; end
        e.irw = 1; e.pcw = 1;
        cyc(ins, 1'b1, rb(), e);
        e = base(S_DECODE); e.srcb = 2'b11; e.aluop = ADD;
        cyc(ins, rb(), rb(), e);
        if (op == 6'h3F) begin
            ret_m++;
            for (int i = 0; i < hc; i++) cyc(ins, rb(), logic'(i == hc - 1), base(S_HALT));
            return;
        end
        if (!is_legal(op)) begin
            ill_m = 1'b1;
            err_halt(ins, hc);
            return;
        end
        case (op)
            6'h00: begin
                e = base(S_R_EXEC); e.srca = 1; e.aluop = op;
                cyc(ins, rb(), rb(), e);
                if (ins[5:0] == 6'h08) begin
                    e = base(S_JR); e.pcw = 1; e.pcsrc = 2'b11;
                end else begin
                    e = base(S_R_WB); e.rdst = 1; e.rw = 1;
                end
                cyc(ins, rb(), rb(), e);
                ret_m++;
            end
            6'h02, 6'h03: begin
                e = base(S_JUMP); e.pcw = 1; e.pcsrc = 2'b10;
                e.jal = (op == 6'h03); e.rw = (op == 6'h03);
                cyc(ins, rb(), rb(), e);
                ret_m++;
            end
            6'h04, 6'h05: begin
                e = base(S_BRANCH); e.srca = 1; e.aluop = op; e.pcwc = 1; e.pcsrc = 2'b01;
                cyc(ins, rb(), rb(), e);
                ret_m++;
            end
            6'h23, 6'h2B: begin
                e = base(S_MEM_ADDR); e.srca = 1; e.srcb = 2'b10; e.aluop = ADD; e.sgn = 1;
                cyc(ins, rb(), rb(), e);
                e = base(op == 6'h23 ? S_MEM_RD : S_MEM_WR); e.iord = 1;
                if (op == 6'h23) e.mrd = 1; else e.mwr = 1;
                wait_phase(ins, e, mw, to);
                if (to) begin err_halt(ins, hc); return; end
                if (rst_mid == 2) begin do_reset(); return; end
                cyc(ins, 1'b1, rb(), e);
                if (op == 6'h23) begin
                    e = base(S_MEM_WB); e.m2r = 1; e.rw = 1;
                    cyc(ins, rb(), rb(), e);
                end
                ret_m++;
            end
            default: begin
                e = base(S_I_EXEC); e.srca = 1; e.srcb = 2'b10; e.aluop = op;
                e.sgn = (op == 6'h09) || (op == 6'h0A);
                cyc(ins, rb(), rb(), e);
                e.st = S_I_WB; e.rw = 1;
                cyc(ins, rb(), rb(), e);
                ret_m++;
            end
        endcase
    endtask

    task automatic run_random(input int n, input bit no_err);
        logic [31:0] r, ins;
        logic [5:0] op;
        for (int i = 0; i < n; i++) begin
            op = rand_op(no_err);
            r = $urandom();
            ins = {op, r[25:0]};
            if (op == 6'h00 && r[31:30] == 2'b00) ins[5:0] = 6'h08;
            run_instr(ins, pick_wait(no_err), pick_wait(no_err), $urandom_range(1, 3), 0);
            if (dead) do_reset();
        end
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                checks++;
                if (a === e) passes++;
                else begin
                    fails++;
                    $display("FAIL cycle_check t=%0t state=%0d: got %h required %h",
                             $time, e.st, a, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        do_reset();
        run_instr(32'h24010005, 0, 0, 1, 0);               // addiu
        run_instr(32'h8C220004, 0, 3, 1, 0);               // lw, 3 wait cycles
        run_instr(32'hAC220004, 0, 10, 3, 0);              // sw, memory stuck -> bus error
        do_reset();
        run_instr(32'hFC000000, 1, 0, 2, 0);               // halt, resume after 2 cycles
        run_instr(32'hEC000000, 0, 0, 2, 0);               // opcode 0x3B: illegal
        do_reset();
        run_instr(32'h24010005, 2, 0, 1, 1);               // reset mid-FETCH wait
        run_instr(32'hAC220004, 0, 1, 1, 2);               // reset mid-MEM_WR wait
        run_instr(32'h10220003, 0, 0, 1, 0);               // beq
        run_instr(32'h0C000010, 0, 0, 1, 0);               // jal
        run_instr(32'h03E00008, 0, 0, 1, 0);               // jr
        run_instr(32'h10220003, 6, 0, 2, 0);               // fetch timeout
        do_reset();
        run_random(70, 1);                                  // long error-free run wraps instret
        run_random(300, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else begin
            fails++;
            $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
